// File: rtl/rv32i_pkg.sv
// Shared types for the ID/EX pipeline register: ALU op codes, operand selects,
// the held-instruction entry and the two-entry skid buffer state.
package rv32i_pkg;

    localparam int XLEN    = 32;
    localparam int XREG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic {
        A_RS1 = 1'b0,
        A_PC  = 1'b1
    } a_sel_t;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [XLEN-1:0]    imm;
        logic [XREG_AW-1:0] rs1_addr;
        logic [XREG_AW-1:0] rs2_addr;
        logic [XREG_AW-1:0] rd;
        alu_op_t            alu_op;
        a_sel_t             a_sel;
        b_sel_t             b_sel;
        logic               we;
    } ex_entry_t;

endpackage

// File: rtl/fwd_unit.sv
// Writeback bypass for one source operand: substitutes the writeback value
// when it targets this operand's register (never x0).
module fwd_unit #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [WIDTH-1:0]  i_wb_data,
    output logic [WIDTH-1:0]  o_data
);

    logic w_hit;

    assign w_hit  = i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_addr);
    assign o_data = w_hit ? i_wb_data : i_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer: o_ready depends only
// on occupancy, and held operands keep tracking writebacks until they issue.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int REG_AW = XREG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_pc,
    input  logic [WIDTH-1:0]  i_rs1_data,
    input  logic [WIDTH-1:0]  i_rs2_data,
    input  logic [WIDTH-1:0]  i_imm,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [3:0]        i_alu_op,
    input  logic              i_a_sel,
    input  logic              i_b_sel,
    input  logic              i_we,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [WIDTH-1:0]  i_wb_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [3:0]        o_alu_op,
    output logic [WIDTH-1:0]  o_a,
    output logic [WIDTH-1:0]  o_b,
    output logic [WIDTH-1:0]  o_pc,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_we
);

    stage_state_t r_state;
    ex_entry_t    r_main;
    ex_entry_t    r_skid;

    ex_entry_t    w_new;
    ex_entry_t    w_main_upd;
    ex_entry_t    w_skid_upd;
    logic         w_in;
    logic         w_out;

    logic [WIDTH-1:0] w_new_rs1, w_new_rs2;
    logic [WIDTH-1:0] w_main_rs1, w_main_rs2;
    logic [WIDTH-1:0] w_skid_rs1, w_skid_rs2;

    assign o_valid = (r_state != EMPTY);
    assign o_ready = (r_state != TWO);
    assign w_in    = i_valid && o_ready;
    assign w_out   = o_valid && i_ready;

    // Capture-time bypass for the incoming instruction
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_new_rs1 (
        .i_addr(i_rs1_addr), .i_data(i_rs1_data), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_new_rs1));
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_new_rs2 (
        .i_addr(i_rs2_addr), .i_data(i_rs2_data), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_new_rs2));

    // Hold-time bypass for the main and skid entries
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_main_rs1 (
        .i_addr(r_main.rs1_addr), .i_data(r_main.rs1), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_main_rs1));
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_main_rs2 (
        .i_addr(r_main.rs2_addr), .i_data(r_main.rs2), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_main_rs2));
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_skid_rs1 (
        .i_addr(r_skid.rs1_addr), .i_data(r_skid.rs1), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_skid_rs1));
    fwd_unit #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_skid_rs2 (
        .i_addr(r_skid.rs2_addr), .i_data(r_skid.rs2), .i_wb_we(i_wb_we),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_data(w_skid_rs2));

    always_comb begin
        w_new          = '0;
        w_new.pc       = i_pc;
        w_new.rs1      = w_new_rs1;
        w_new.rs2      = w_new_rs2;
        w_new.imm      = i_imm;
        w_new.rs1_addr = i_rs1_addr;
        w_new.rs2_addr = i_rs2_addr;
        w_new.rd       = i_rd;
        w_new.alu_op   = alu_op_t'(i_alu_op);
        w_new.a_sel    = a_sel_t'(i_a_sel);
        w_new.b_sel    = b_sel_t'(i_b_sel);
        w_new.we       = i_we;

        w_main_upd     = r_main;
        w_main_upd.rs1 = w_main_rs1;
        w_main_upd.rs2 = w_main_rs2;

        w_skid_upd     = r_skid;
        w_skid_upd.rs1 = w_skid_rs1;
        w_skid_upd.rs2 = w_skid_rs2;
    end

    // Held entries absorb writebacks every edge; transfers override below.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_main <= w_main_upd;
            r_skid <= w_skid_upd;
            if (i_flush) begin
                r_state <= EMPTY;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_in) begin
                            r_main  <= w_new;
                            r_state <= ONE;
                        end
                    end
                    ONE: begin
                        case ({w_in, w_out})
                            2'b11: r_main <= w_new;
                            2'b10: begin
                                r_skid  <= w_new;
                                r_state <= TWO;
                            end
                            2'b01: r_state <= EMPTY;
                            default: ;
                        endcase
                    end
                    TWO: begin
                        if (w_out) begin
                            r_main  <= w_skid_upd;
                            r_state <= ONE;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end
    end

    assign o_alu_op = r_main.alu_op;
    assign o_a      = (r_main.a_sel == A_PC)  ? r_main.pc  : r_main.rs1;
    assign o_b      = (r_main.b_sel == B_IMM) ? r_main.imm : r_main.rs2;
    assign o_pc     = r_main.pc;
    assign o_rd     = r_main.rd;
    assign o_we     = r_main.we && o_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_id_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0;
    logic [4:0]  i_rs1_addr = '0, i_rs2_addr = '0, i_rd = '0;
    logic [3:0]  i_alu_op = '0;
    logic        i_a_sel = 1'b0, i_b_sel = 1'b0, i_we = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [3:0]  o_alu_op;
    logic [31:0] o_a, o_b, o_pc;
    logic [4:0]  o_rd;
    logic        o_we;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd(i_rd),
        .i_alu_op(i_alu_op), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel), .i_we(i_we),
        .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_alu_op(o_alu_op), .o_a(o_a), .o_b(o_b), .o_pc(o_pc), .o_rd(o_rd), .o_we(o_we));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got pc=%h a=%h b=%h expected no output", o_pc, o_a, o_b);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (o_a !== e.a || o_b !== e.b || o_pc !== e.pc || o_rd !== e.rd ||
                        o_we !== e.we || o_alu_op !== e.op) begin
                        errors++;
                        $display("FAIL output: got a=%h b=%h pc=%h rd=%0d we=%b op=%0d expected a=%h b=%h pc=%h rd=%0d we=%b op=%0d",
                                 o_a, o_b, o_pc, o_rd, o_we, o_alu_op, e.a, e.b, e.pc, e.rd, e.we, e.op);
                    end
                end
            end
        end
    end

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] rd, input logic [3:0] op, input logic as,
                             input logic bs, input logic we);
        i_pc = pc; i_rs1_data = r1; i_rs2_data = r2; i_imm = imm;
        i_rs1_addr = a1; i_rs2_addr = a2; i_rd = rd; i_alu_op = op;
        i_a_sel = as; i_b_sel = bs; i_we = we;
    endtask

    // Offers the staged instruction until accepted; optionally records the expected output.
    task automatic send(input logic [31:0] ea, input logic [31:0] eb, input logic push);
        bit acc = 0;
        exp_t e;
        i_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1");
        end else if (push) begin
            e.a = ea; e.b = eb; e.pc = i_pc; e.rd = i_rd; e.we = i_we; e.op = i_alu_op;
            sb.push_back(e);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_we", {31'd0, o_we}, 32'd0);
        chk("rst_o_a", o_a, 32'd0);
        chk("rst_o_b", o_b, 32'd0);
        chk("rst_o_pc", o_pc, 32'd0);
        chk("rst_o_rd", {27'd0, o_rd}, 32'd0);
        chk("rst_o_alu_op", {28'd0, o_alu_op}, 32'd0);
        @(negedge i_clk); i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_o_ready", {31'd0, o_ready}, 32'd1);

        // Basic ADD, one-cycle latency
        i_ready = 1'b1;
        set_instr(32'h100, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd6, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'd5, 32'd7, 1'b1);
        chk("latency_o_valid", {31'd0, o_valid}, 32'd1);
        chk("latency_o_a", o_a, 32'd5);
        @(posedge i_clk); #1;

        // pc / imm operand selection
        set_instr(32'h200, 32'h1, 32'h2, 32'h10, 5'd1, 5'd2, 5'd7, 4'd1, 1'b1, 1'b1, 1'b0);
        send(32'h200, 32'h10, 1'b1);

        // Back-to-back under stall: two accepted, third refused
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        set_instr(32'h300, 32'hA1, 32'hA2, 32'h0, 5'd8, 5'd9, 5'd10, 4'd2, 1'b0, 1'b0, 1'b1);
        send(32'hA1, 32'hA2, 1'b1);
        chk("stall_ready_after_1", {31'd0, o_ready}, 32'd1);
        set_instr(32'h304, 32'hB1, 32'hB2, 32'h44, 5'd11, 5'd12, 5'd13, 4'd3, 1'b0, 1'b1, 1'b1);
        send(32'hB1, 32'h44, 1'b1);
        chk("stall_ready_after_2", {31'd0, o_ready}, 32'd0);
        set_instr(32'h308, 32'hC1, 32'hC2, 32'h0, 5'd14, 5'd15, 5'd16, 4'd4, 1'b0, 1'b0, 1'b1);
        i_valid = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("stall_third_refused_ready", {31'd0, o_ready}, 32'd0);
        chk("stall_head_pc", o_pc, 32'h300);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("stall_drained", sb.size(), 32'd0);

        // Capture bypass, and x0 never bypassed
        i_wb_we = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'hDEAD;
        set_instr(32'h400, 32'h11, 32'h22, 32'h0, 5'd3, 5'd2, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'hDEAD, 32'h22, 1'b1);
        i_wb_rd = 5'd0;
        set_instr(32'h404, 32'h11, 32'h22, 32'h0, 5'd3, 5'd2, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h11, 32'h22, 1'b1);
        set_instr(32'h408, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h33, 32'h44, 1'b1);
        i_wb_we = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;

        // Writeback while held in TWO updates the skid entry
        i_ready = 1'b0;
        set_instr(32'h500, 32'h20, 32'h21, 32'h0, 5'd5, 5'd1, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h20, 32'h21, 1'b1);
        set_instr(32'h504, 32'h30, 32'h09, 32'h0, 5'd6, 5'd4, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h30, 32'h55, 1'b1);
        i_wb_we = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'h55;
        @(posedge i_clk); #1;
        i_wb_we = 1'b0; i_wb_data = 32'h0;
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;

        // Flush in TWO with a simultaneous offer
        i_ready = 1'b0;
        set_instr(32'h600, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b0);
        set_instr(32'h604, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b0);
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_o_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_o_ready", {31'd0, o_ready}, 32'd1);
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;

        // Asynchronous reset while holding a valid entry
        i_ready = 1'b0;
        set_instr(32'h700, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b0);
        chk("pre_rst_o_valid", {31'd0, o_valid}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("async_rst_o_we", {31'd0, o_we}, 32'd0);
        @(negedge i_clk); i_rst = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
